// File: rtl/runway_pkg.sv
// runway_pkg: shared types for the runway-lights datapath.
//   wind_t       - legal wind codes seen by the light sequencer
//   WIND_ILLEGAL - the switch combination that is never forwarded
//   deb_state_t  - debounce controller states
//   is_legal()   - true for any code the sequencer may receive
package runway_pkg;

    typedef enum logic [1:0] {
        CALM = 2'b00,
        RTOL = 2'b01,
        LTOR = 2'b10
    } wind_t;

    localparam logic [1:0] WIND_ILLEGAL = 2'b11;

    typedef enum logic {
        STEADY = 1'b0,
        SETTLE = 1'b1
    } deb_state_t;

    function automatic logic is_legal(input logic [1:0] code);
        return code != WIND_ILLEGAL;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: per-bit two-flop synchroniser for signals arriving asynchronously
// to clk. Only the second stage is meant to be consumed.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-low reset, both stages clear to 0
//   d     - asynchronous input bits
//   q     - synchronised output bits (two clk edges of latency)
module sync_2ff #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic s1_reg;
        logic s2_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= d[gi];
                s2_reg <= s1_reg;
            end
        end

        assign q[gi] = s2_reg;
    end

endmodule

// File: rtl/wind_input_conditioner.sv
// wind_input_conditioner: turns the two raw wind-direction switches into a
// clean, legal wind code for the runway light sequencer. The switches are
// synchronised, debounced (STABLE_CYCLES consecutive cycles), and the illegal
// code 11 is never forwarded; instead it raises fault.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset (release synchronous to clk)
//   sw_raw    - raw switches; bit0 = right-to-left, bit1 = left-to-right
//   w         - accepted wind code (CALM/RTOL/LTOR, never 11)
//   w_changed - one-cycle pulse in the cycle w takes a new value
//   fault     - high while the debounced input is stable at 11
// Build option: define WIND_HOLDOFF_EN to enforce a minimum dwell of
// HOLD_CYCLES after every change of w before another change is taken.
module wind_input_conditioner
    import runway_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    output logic [1:0] w,
    output logic       w_changed,
    output logic       fault
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       s2;
    deb_state_t       state_reg, state_next;
    logic [1:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    wind_t            w_reg, w_next;
    logic             w_changed_reg, w_changed_next;
    logic             fault_reg, fault_next;
    logic             hold_busy;

    sync_2ff #(
        .WIDTH(2)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (s2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= STEADY;
            cand_reg      <= 2'b00;
            cnt_reg       <= '0;
            w_reg         <= CALM;
            w_changed_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            w_reg         <= w_next;
            w_changed_reg <= w_changed_next;
            fault_reg     <= fault_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        cnt_next       = cnt_reg;
        w_next         = w_reg;
        w_changed_next = 1'b0;
        fault_next     = fault_reg;

        // Any movement of the synchronised input restarts the stability window.
        if (s2 != cand_reg) begin
            cand_next  = s2;
            cnt_next   = '0;
            state_next = SETTLE;
        end else begin
            case (state_reg)
                STEADY: begin
                end
                SETTLE: begin
                    if (cnt_reg < CNT_LAST) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else begin
                        state_next = STEADY;
                        if (!is_legal(cand_reg)) begin
                            // w keeps its last legal value.
                            fault_next = 1'b1;
                        end else if (cand_reg == w_reg) begin
                            fault_next = 1'b0;
                        end else if (hold_busy) begin
                            // Dwell not over: park in SETTLE with the count
                            // saturated so the change lands as soon as it ends.
                            state_next = SETTLE;
                        end else begin
                            w_next         = wind_t'(cand_reg);
                            w_changed_next = 1'b1;
                            fault_next     = 1'b0;
                        end
                    end
                end
                default: state_next = STEADY;
            endcase
        end
    end

`ifdef WIND_HOLDOFF_EN
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg <= '0;
        end else if (w_changed_next) begin
            hold_reg <= HOLD_LOAD;
        end else if (hold_reg != '0) begin
            hold_reg <= hold_reg - HOLD_W'(1);
        end
    end

    assign hold_busy = (hold_reg != '0);
`else
    // No dwell counter in this build; HOLD_CYCLES only shapes it when enabled,
    // so it is merely referenced here.
    if (HOLD_CYCLES < 1) begin : g_hold_absent
    end

    assign hold_busy = 1'b0;
`endif

    assign w         = w_reg;
    assign w_changed = w_changed_reg;
    assign fault     = fault_reg;

endmodule

// File: doc/wind_input_conditioner.md
Name: wind_input_conditioner

Overview:
- Upstream stage of the runway-lights FSM: takes the two raw wind-direction switches and produces a clean, legal 2-bit wind code for the light sequencer.
- Synchronises the switches into clk, debounces them and rejects the illegal code 2'b11.
- Emits a one-cycle strobe on every accepted direction change.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles the synchronised input must hold before it is accepted; legal range 2..255.
- CNT_W, $clog2(STABLE_CYCLES+1): debounce counter width; derived, never overridden.
- HOLD_CYCLES, 8: minimum dwell after an accepted change; used only with WIND_HOLDOFF_EN.

Ports:
- clk, input, 1: single system clock; all state is updated on its rising edge.
- reset, input, 1: asynchronous, active-low reset; 0 = in reset; assertion is immediate, release is synchronous to clk.
- sw_raw, input, 2: raw switches, asynchronous to clk. Bit0 = right-to-left, bit1 = left-to-right.
- w, output, 2: accepted wind code of type wind_t: CALM=00, RTOL=01, LTOR=10. Never 11.
- w_changed, output, 1: one-cycle pulse in the cycle w takes a new value.
- fault, output, 1: high while the debounced input is stable at 11.

Behaviour:
- Reset values (all registers while reset=0): sync stages 00, candidate 00, counter 0, w=CALM, w_changed=0, fault=0, FSM=STEADY.
- Synchroniser: two flops per bit, s1 <= sw_raw and s2 <= s1. Only s2 is used downstream.
- Debounce, evaluated each edge:
  - If s2 != cand: cand <= s2, cnt <= 0, FSM <= SETTLE.
  - Else if FSM==SETTLE and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Else if FSM==SETTLE and cnt == STABLE_CYCLES-1: accept cand, FSM <= STEADY.
- Acceptance:
  - cand in {00,01,10} and cand != w: w <= cand, w_changed <= 1, fault <= 0.
  - cand == w: no w_changed pulse; fault <= 0.
  - cand == 11: w holds its last legal value, fault <= 1, no w_changed pulse.
- Latency: let E0 be the first edge at which sw_raw has its new value. w updates at edge E(STABLE_CYCLES+2), i.e. E6 for the default. w_changed is high for exactly the cycle after that edge.
- Glitches: any change of s2 during SETTLE restarts the count from 0. A glitch shorter than STABLE_CYCLES never reaches w.
- FSM states:
  - STEADY: cnt frozen.
  - SETTLE: counting.
  - No other states. Unreachable encodings return to STEADY.
- Reset asserted mid-SETTLE: the count is abandoned and all state returns to reset values. After release, w stays CALM until a new input is accepted.
- w_changed and fault are registered outputs; there are no combinational input-to-output paths.

Optional Feature:
- Macro: WIND_HOLDOFF_EN.
- Defined:
  - After any w change, a hold counter loads HOLD_CYCLES-1 and decrements to 0.
  - While it is nonzero, an acceptance that would change w is deferred: FSM stays in SETTLE with cnt saturated.
  - The change is taken on the first edge after the hold reaches 0, provided cand is still stable.
  - The fault flag is not subject to the hold.
- Undefined: no hold counter exists; acceptance is exactly as in Behaviour.

Decomposition:
- Package runway_pkg holds:
  - typedef enum logic [1:0] wind_t {CALM=2'b00, RTOL=2'b01, LTOR=2'b10}
  - localparam WIND_ILLEGAL=2'b11
  - typedef enum logic {STEADY, SETTLE} deb_state_t
- The downstream light FSM imports the same wind_t.
- One natural sub-module: sync_2ff, a parameterised-width two-flop synchroniser with the same clk and reset (active-low async), reused for the 2-bit input.

Test Plan:
- Reset release with sw_raw=00 held -> w=CALM, w_changed=0 and fault=0 for 20 cycles.
- sw_raw 00->01 at E0 and held (STABLE_CYCLES=4) -> w=RTOL at E6, w_changed high for exactly one cycle, w unchanged before E6.
- sw_raw pulses 01 for 3 cycles, then returns to 00 -> w stays CALM, w_changed never asserts.
- sw_raw=11 held from a w=LTOR state -> fault=1 at E6, w stays LTOR. Then sw_raw=00 -> fault=0 and w=CALM four cycles after the synchronised change, with one w_changed pulse.
- reset pulsed low mid-SETTLE toward LTOR -> outputs go to reset values immediately. After release with sw_raw still 10, w=LTOR at E6 counted from the first edge after release.
- WIND_HOLDOFF_EN, HOLD_CYCLES=8: 00->01, then 01->10 two cycles after the acceptance -> second change is deferred until the hold expires; the two w_changed pulses are at least 8 cycles apart.
